// File: rtl/datapath_pkg.sv
// Shared definitions for the command-driven accumulator datapath.
// Holds the ALU opcode encoding and the sequencer state encoding.
// Both are used by datapath_seq and alu_w.
package datapath_pkg;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_PASS = 3'b101,
      OP_SHL  = 3'b110,
      OP_SAR  = 3'b111
   } op_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

endpackage

// File: rtl/alu_w.sv
// Combinational W-bit ALU for the accumulator datapath.
// Ports:
//   op  - opcode (datapath_pkg::op_e encoding)
//   a   - accumulator value
//   b   - selected operand
//   res - result, truncated to W bits
//   ovf - signed overflow for ADD/SUB/SHL, 0 for all other ops
module alu_w
   import datapath_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] res,
   output logic         ovf
);

   always_comb begin
      res = '0;
      ovf = 1'b0;
      case (op)
         OP_ADD: begin
            res = a + b;
            // Same-sign operands producing a differently signed sum.
            ovf = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
         end
         OP_SUB: begin
            res = a - b;
            // Opposite-sign operands where the sign of a flips.
            ovf = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
         end
         OP_AND:  res = a & b;
         OP_OR:   res = a | b;
         OP_XOR:  res = a ^ b;
         OP_PASS: res = b;
         OP_SHL: begin
            res = {a[W-2:0], 1'b0};
            // Doubling overflows when the top two bits disagree.
            ovf = a[W-1] ^ a[W-2];
         end
         OP_SAR:  res = {a[W-1], a[W-1:1]};
         default: begin
            res = '0;
            ovf = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/datapath_seq.sv
// Command sequencer around a W-bit accumulator.
// Commands (operand channel + opcode) are accepted in RUN; the command
// flagged cmd_last moves the block to HOLD, where the accumulated result
// with sticky overflow/error flags and a saturating command count is
// offered until consumed, then the flags/count clear (acc is kept).
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   src                             - NSRC flattened W-bit operand channels
//   cmd_valid/cmd_ready             - command handshake
//   cmd_sel, cmd_op, cmd_last       - command payload
//   res_valid/res_ready             - result handshake
//   res_data/res_ovf/res_err/res_count - result payload
//   acc_out                         - live accumulator
module datapath_seq
   import datapath_pkg::*;
#(
   parameter int W    = 8,
   parameter int NSRC = 4,
   parameter int SELW = 2,
   parameter int CW   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NSRC*W-1:0] src,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [SELW-1:0]   cmd_sel,
   input  logic [2:0]        cmd_op,
   input  logic              cmd_last,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [W-1:0]      res_data,
   output logic              res_ovf,
   output logic              res_err,
   output logic [CW-1:0]     res_count,
   output logic [W-1:0]      acc_out
);

   localparam int NCH = 2**SELW;

   state_e          state_reg, state_next;
   logic [W-1:0]    acc_reg,   acc_next;
   logic            ovf_reg,   ovf_next;
   logic            err_reg,   err_next;
   logic [CW-1:0]   cnt_reg,   cnt_next;

   // Select space padded to 2**SELW entries: indices past NSRC read as
   // zero and are marked invalid, so no width-mismatched compare is needed.
   logic [W-1:0]    chan [NCH];
   logic [NCH-1:0]  chan_ok;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      if (gi < NSRC) begin : g_real
         assign chan[gi]    = src[gi*W +: W];
         assign chan_ok[gi] = 1'b1;
      end else begin : g_pad
         assign chan[gi]    = '0;
         assign chan_ok[gi] = 1'b0;
      end
   end

   logic [W-1:0] opnd;
   logic         sel_err;
   logic [W-1:0] alu_res;
   logic         alu_ovf;

   assign opnd    = chan[cmd_sel];
   assign sel_err = ~chan_ok[cmd_sel];

   alu_w #(.W(W)) u_alu (
      .op  (cmd_op),
      .a   (acc_reg),
      .b   (opnd),
      .res (alu_res),
      .ovf (alu_ovf)
   );

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      ovf_next   = ovf_reg;
      err_next   = err_reg;
      cnt_next   = cnt_reg;
      cmd_ready  = 1'b0;
      res_valid  = 1'b0;
      case (state_reg)
         ST_RUN: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               acc_next = alu_res;
               ovf_next = ovf_reg | alu_ovf;
               err_next = err_reg | sel_err;
               if (cnt_reg != {CW{1'b1}})
                  cnt_next = cnt_reg + CW'(1);
               if (cmd_last)
                  state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_next = ST_RUN;
               ovf_next   = 1'b0;
               err_next   = 1'b0;
               cnt_next   = '0;
            end
         end
         default: state_next = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_RUN;
         acc_reg   <= '0;
         ovf_reg   <= 1'b0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         ovf_reg   <= ovf_next;
         err_reg   <= err_next;
         cnt_reg   <= cnt_next;
      end
   end

   // In HOLD nothing but res_ready can change these registers, so the
   // result outputs are stable without a separate capture register.
   assign res_data  = acc_reg;
   assign res_ovf   = ovf_reg;
   assign res_err   = err_reg;
   assign res_count = cnt_reg;
   assign acc_out   = acc_reg;

endmodule

// File: doc/datapath_seq.md
DATAPATH_SEQ -- requirements
Module: datapath_seq

Interface
REQ-001 SHALL have parameter W, default 8, operand/accumulator width (W >= 2).
REQ-002 SHALL have parameter NSRC, default 4, number of operand channels (NSRC >= 1).
REQ-003 SHALL have parameter SELW, default 2, source-select width (2**SELW >= NSRC).
REQ-004 SHALL have parameter CW, default 8, command-counter width.
REQ-005 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port src, input, NSRC*W, flattened operand channels; channel i is bits [i*W +: W].
REQ-008 SHALL have port cmd_valid, input, 1, command offered.
REQ-009 SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
REQ-010 SHALL have port cmd_sel, input, SELW, operand channel index.
REQ-011 SHALL have port cmd_op, input, 3, ALU opcode.
REQ-012 SHALL have port cmd_last, input, 1, final command of a sequence.
REQ-013 SHALL have port res_valid, output, 1, sequence result available.
REQ-014 SHALL have port res_ready, input, 1, result consumed when res_valid && res_ready.
REQ-015 SHALL have port res_data, output, W, accumulator value at end of sequence.
REQ-016 SHALL have port res_ovf, output, 1, sticky signed overflow over the sequence.
REQ-017 SHALL have port res_err, output, 1, sticky invalid-select flag over the sequence.
REQ-018 SHALL have port res_count, output, CW, commands accepted in the sequence, saturating at 2**CW-1.
REQ-019 SHALL have port acc_out, output, W, live accumulator value at all times.

Function
REQ-020 SHALL implement two states: RUN (cmd_ready=1, res_valid=0) and HOLD (cmd_ready=0, res_valid=1).
REQ-021 SHALL, on each accepted command, write acc <= ALU(op, acc, operand) at that edge; acc_out shows it the next cycle.
REQ-022 SHALL decode cmd_op: 000 ADD acc+opnd; 001 SUB acc-opnd; 010 AND; 011 OR; 100 XOR; 101 PASS opnd; 110 SHL acc by 1; 111 SAR acc by 1; all results truncated to W bits.
REQ-023 SHALL set overflow for ADD/SUB on two's-complement signed overflow, for SHL when acc[W-1] != acc[W-2], otherwise 0.
REQ-024 SHALL use operand value 0 and set sticky error when cmd_sel >= NSRC; the op still executes.
REQ-025 SHALL OR per-command overflow/error into sticky flags and increment the counter, saturating, per accepted command.
REQ-026 SHALL transition RUN->HOLD on the edge accepting a command with cmd_last=1; res_valid rises the next cycle with that command's result included.
REQ-027 SHALL hold res_data, res_ovf, res_err and res_count stable while in HOLD, regardless of cmd_valid or src changes.
REQ-028 SHALL transition HOLD->RUN on res_valid && res_ready, clearing sticky flags and counter at that edge; acc is retained.
REQ-029 SHALL ignore cmd_valid in HOLD; no command is consumed and acc is unchanged.
REQ-030 SHALL drive res_data equal to acc_out in HOLD.

Reset
REQ-031 SHALL, when reset is high at a clock edge, force state RUN, acc 0, sticky flags 0, counter 0, overriding any simultaneous handshake.
REQ-032 SHALL, out of reset, present cmd_ready=1, res_valid=0, res_data=0, res_ovf=0, res_err=0, res_count=0, acc_out=0.
REQ-033 SHALL abandon any partial sequence on reset mid-operation without emitting a result.

Structure
REQ-034 SHALL place opcode constants and state encoding in a shared package, datapath_pkg.
REQ-035 SHALL instantiate one combinational sub-module alu_w (parameter W) producing result and overflow.

Verification
REQ-036 SHALL cover: reset; PASS src0=0x10, ADD src1=0x20 last -> res_data 0x30, ovf 0, err 0, count 2.
REQ-037 SHALL cover: PASS 0x7F, ADD 0x01 last -> res_data 0x80, ovf 1; next sequence PASS 0x01 last -> ovf 0, count 1.
REQ-038 SHALL cover: res_ready low 3 cycles in HOLD with cmd_valid high -> res_valid held, cmd_ready 0, outputs stable, acc unchanged.
REQ-039 SHALL cover: NSRC=3, cmd_sel=3 PASS last -> res_data 0x00, err 1.
REQ-040 SHALL cover: PASS 0x40, SHL, SAR last -> after SHL acc 0x80 with ovf set; result 0xC0, ovf 1.
REQ-041 SHALL cover: reset asserted after two commands mid-sequence -> acc_out 0, count 0, no res_valid pulse.
